// File: rtl/trap_pkg.sv
// Shared encodings for the execute-stage trap sequencer: MIPS decode fields,
// CP0 cause codes, CP0 choice bit positions and the sequencer state type.
package trap_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_COP0    = 6'h10;

    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_TEQ     = 6'h34;
    localparam logic [5:0] FN_ERET    = 6'h18;

    localparam logic [4:0] RS_CO = 5'h10;
    localparam logic [4:0] RS_MT = 5'h04;
    localparam logic [4:0] RS_MF = 5'h00;

    localparam logic [3:0] CAUSE_SYS  = 4'b1000;
    localparam logic [3:0] CAUSE_BP   = 4'b1001;
    localparam logic [3:0] CAUSE_TR   = 4'b1101;
    localparam logic [3:0] CAUSE_NONE = 4'b0000;

    localparam int unsigned CH_TEQ  = 3;
    localparam int unsigned CH_ERET = 2;
    localparam int unsigned CH_MTC0 = 1;
    localparam int unsigned CH_MFC0 = 0;

    // Wide enough for the 1..7 flush-cycle range.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StTrap,
        StRedir,
        StFlush,
        StMfcWb
    } state_e;

endpackage

// File: rtl/trap_decode.sv
// Combinational classifier for the CP0-related instructions handled by the
// trap sequencer, plus the CP0 cause code for the exception-raising ones.
module trap_decode
    import trap_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs_fld,
    input  logic [5:0] funct,
    output logic       is_syscall,
    output logic       is_break,
    output logic       is_teq,
    output logic       is_eret,
    output logic       is_mtc0,
    output logic       is_mfc0,
    output logic [3:0] cause
);

    assign is_syscall = (op == OP_SPECIAL) && (funct == FN_SYSCALL);
    assign is_break   = (op == OP_SPECIAL) && (funct == FN_BREAK);
    assign is_teq     = (op == OP_SPECIAL) && (funct == FN_TEQ);
    assign is_eret    = (op == OP_COP0) && (rs_fld == RS_CO) && (funct == FN_ERET);
    assign is_mtc0    = (op == OP_COP0) && (rs_fld == RS_MT);
    assign is_mfc0    = (op == OP_COP0) && (rs_fld == RS_MF);

    always_comb begin
        cause = CAUSE_NONE;
        if (is_syscall) begin
            cause = CAUSE_SYS;
        end else if (is_break) begin
            cause = CAUSE_BP;
        end else if (is_teq) begin
            cause = CAUSE_TR;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Execute-stage controller feeding CP0: sequences trap/return redirects and MFC0 writeback.
// Define TRAP_SEQ_STATS_EN to add the trap_count/eret_count statistics outputs.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] rs_data,
    input  logic [PC_W-1:0] rt_data,
    input  logic [PC_W-1:0] cp0_exc_addr,
    input  logic [PC_W-1:0] cp0_rdata,
    output logic [3:0]      cp0_choice,
    output logic [3:0]      cp0_cause,
    output logic [4:0]      cp0_addr,
    output logic [PC_W-1:0] cp0_wdata,
    output logic [PC_W-1:0] cp0_pc,
    output logic            stall,
    output logic            flush,
    output logic            pc_redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [PC_W-1:0] rf_wdata
`ifdef TRAP_SEQ_STATS_EN
    ,
    output logic [31:0]     trap_count,
    output logic [31:0]     eret_count
`endif
);

    logic is_syscall, is_break, is_teq, is_eret, is_mtc0, is_mfc0;
    logic [3:0] dec_cause;
    logic       teq_taken;
    logic       unused_shamt;

    state_e            state_q, state_d;
    logic [3:0]        cause_q, cause_d;
    logic [PC_W-1:0]   tpc_q, tpc_d;
    logic              eret_q, eret_d;
    logic              teq_q, teq_d;
    logic [PC_W-1:0]   redir_q, redir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [PC_W-1:0]   wb_data_q, wb_data_d;

    trap_decode u_decode (
        .op         (instr[31:26]),
        .rs_fld     (instr[25:21]),
        .funct      (instr[5:0]),
        .is_syscall (is_syscall),
        .is_break   (is_break),
        .is_teq     (is_teq),
        .is_eret    (is_eret),
        .is_mtc0    (is_mtc0),
        .is_mfc0    (is_mfc0),
        .cause      (dec_cause)
    );

    assign teq_taken    = is_teq && (rs_data == rt_data);
    assign unused_shamt = ^instr[10:6];
    assign redirect_pc  = redir_q;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        tpc_d       = tpc_q;
        eret_d      = eret_q;
        teq_d       = teq_q;
        redir_d     = redir_q;
        cnt_d       = cnt_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        cp0_choice  = 4'b0000;
        cp0_cause   = CAUSE_NONE;
        cp0_addr    = 5'd0;
        cp0_wdata   = '0;
        cp0_pc      = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = 5'd0;
        rf_wdata    = '0;

        unique case (state_q)
            StIdle: begin
                // Qualified by rst so held-in-reset issue never reaches CP0 combinationally.
                if (instr_valid && rst) begin
                    if (is_mtc0) begin
                        cp0_choice[CH_MTC0] = 1'b1;
                        cp0_addr            = instr[15:11];
                        cp0_wdata           = rt_data;
                    end else if (is_mfc0) begin
                        cp0_choice[CH_MFC0] = 1'b1;
                        cp0_addr            = instr[15:11];
                        stall               = 1'b1;
                        wb_addr_d           = instr[20:16];
                        wb_data_d           = cp0_rdata;
                        state_d             = StMfcWb;
                    end else if (is_syscall || is_break || teq_taken || is_eret) begin
                        stall   = 1'b1;
                        cause_d = dec_cause;
                        tpc_d   = pc;
                        eret_d  = is_eret;
                        teq_d   = teq_taken;
                        state_d = StTrap;
                    end
                end
            end
            StTrap: begin
                cp0_cause           = cause_q;
                cp0_pc              = tpc_q;
                cp0_choice[CH_TEQ]  = teq_q;
                cp0_choice[CH_ERET] = eret_q;
                stall               = 1'b1;
                // CP0 only presents EPC while eret is asserted, so sample it here.
                redir_d             = cp0_exc_addr;
                state_d             = StRedir;
            end
            StRedir: begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                stall       = 1'b1;
                cnt_d       = CNT_W'(FLUSH_CYCLES);
                state_d     = StFlush;
            end
            StFlush: begin
                flush = 1'b1;
                stall = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StIdle;
                end
            end
            StMfcWb: begin
                rf_we    = 1'b1;
                rf_waddr = wb_addr_q;
                rf_wdata = wb_data_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cause_q   <= CAUSE_NONE;
            tpc_q     <= '0;
            eret_q    <= 1'b0;
            teq_q     <= 1'b0;
            redir_q   <= '0;
            cnt_q     <= '0;
            wb_addr_q <= 5'd0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            tpc_q     <= tpc_d;
            eret_q    <= eret_d;
            teq_q     <= teq_d;
            redir_q   <= redir_d;
            cnt_q     <= cnt_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef TRAP_SEQ_STATS_EN
    // TRAP always leaves for REDIR, so a TRAP cycle marks that transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_count <= '0;
            eret_count <= '0;
        end else if (state_q == StTrap) begin
            if (eret_q) begin
                eret_count <= eret_count + 32'd1;
            end else begin
                trap_count <= trap_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: redirect targets and MFC0 writebacks are
// queued at issue and matched when the DUT emits them.
module tb_trap_sequencer;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr, pc, rs_data, rt_data, cp0_rdata;
    logic [31:0] cp0_exc_addr;
    logic [31:0] epc_model;
    logic [3:0]  cp0_choice, cp0_cause;
    logic [4:0]  cp0_addr, rf_waddr;
    logic [31:0] cp0_wdata, cp0_pc, redirect_pc, rf_wdata;
    logic        stall, flush, pc_redirect, rf_we;
`ifdef TRAP_SEQ_STATS_EN
    logic [31:0] trap_count, eret_count;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic [31:0] redir_q[$];
    wb_t         wb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // CP0 model: EPC only while eret is requested, exception vector otherwise.
    assign cp0_exc_addr = cp0_choice[2] ? epc_model : 32'h0000_0004;

    trap_sequencer #(
        .FLUSH_CYCLES (FC),
        .PC_W         (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .cp0_exc_addr (cp0_exc_addr),
        .cp0_rdata    (cp0_rdata),
        .cp0_choice   (cp0_choice),
        .cp0_cause    (cp0_cause),
        .cp0_addr     (cp0_addr),
        .cp0_wdata    (cp0_wdata),
        .cp0_pc       (cp0_pc),
        .stall        (stall),
        .flush        (flush),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
`ifdef TRAP_SEQ_STATS_EN
        .trap_count   (trap_count),
        .eret_count   (eret_count),
`endif
        .rf_wdata     (rf_wdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (pc_redirect) begin
                if (redir_q.size() == 0) begin
                    check_eq("spurious_redirect", 32'(pc_redirect), 32'h0);
                end else begin
                    automatic logic [31:0] exp_t = redir_q.pop_front();
                    check_eq("redirect_pc", redirect_pc, exp_t);
                end
            end
            if (rf_we) begin
                if (wb_q.size() == 0) begin
                    check_eq("spurious_rf_we", 32'(rf_we), 32'h0);
                end else begin
                    automatic wb_t exp_w = wb_q.pop_front();
                    check_eq("rf_waddr", 32'(rf_waddr), 32'(exp_w.addr));
                    check_eq("rf_wdata", rf_wdata, exp_w.data);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] rsv, input logic [31:0] rtv);
        @(posedge clk);
        #1;
        instr       = ins;
        pc          = p;
        rs_data     = rsv;
        rt_data     = rtv;
        instr_valid = 1'b1;
    endtask

    task automatic release_bus();
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic trap_seq(input string name, input logic [31:0] ins, input logic [31:0] p,
                            input logic [31:0] rsv, input logic [31:0] rtv,
                            input logic [3:0] exp_cause, input logic [3:0] exp_choice,
                            input logic [31:0] exp_target);
        int n_stall;
        int n_flush;
        int n_redir;
        redir_q.push_back(exp_target);
        drive(ins, p, rsv, rtv);
        @(negedge clk);
        check_eq({name, "_issue_stall"}, 32'(stall), 32'h1);
        release_bus();
        @(negedge clk);
        check_eq({name, "_trap_cause"}, 32'(cp0_cause), 32'(exp_cause));
        check_eq({name, "_trap_choice"}, 32'(cp0_choice), 32'(exp_choice));
        check_eq({name, "_trap_pc"}, cp0_pc, p);
        n_stall = 2;
        n_flush = 0;
        n_redir = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            n_flush += int'(flush);
            n_redir += int'(pc_redirect);
        end
        check_eq({name, "_latency"}, 32'(n_stall), 32'(3 + FC));
        check_eq({name, "_flush_cycles"}, 32'(n_flush), 32'(1 + FC));
        check_eq({name, "_redirect_count"}, 32'(n_redir), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        pc          = '0;
        rs_data     = '0;
        rt_data     = '0;
        cp0_rdata   = '0;
        epc_model   = 32'h0040_0024;
        repeat (2) @(negedge clk);
        check_eq("reset_stall", 32'(stall), 32'h0);
        check_eq("reset_choice", 32'(cp0_choice), 32'h0);
        check_eq("reset_redirect", 32'(pc_redirect), 32'h0);
        check_eq("reset_redirect_pc", redirect_pc, 32'h0);
        check_eq("reset_rf_we", 32'(rf_we), 32'h0);
        rst = 1'b1;

        trap_seq("syscall", 32'h0000_000C, 32'h0040_0020, 32'h0, 32'h0,
                 4'b1000, 4'b0000, 32'h0000_0004);
        trap_seq("teq_taken", 32'h0085_0034, 32'h0040_0100, 32'h5, 32'h5,
                 4'b1101, 4'b1000, 32'h0000_0004);

        drive(32'h0085_0034, 32'h0040_0104, 32'h5, 32'h6);
        @(negedge clk);
        check_eq("teq_nt_stall", 32'(stall), 32'h0);
        check_eq("teq_nt_choice", 32'(cp0_choice), 32'h0);
        release_bus();
        @(negedge clk);
        check_eq("teq_nt_after", 32'(stall | pc_redirect | flush), 32'h0);

        trap_seq("eret", 32'h4200_0018, 32'h0040_0200, 32'h0, 32'h0,
                 4'b0000, 4'b0100, 32'h0040_0024);

        drive(32'h4088_6000, 32'h0040_0300, 32'h0, 32'hF);
        @(negedge clk);
        check_eq("mtc0_choice", 32'(cp0_choice), 32'h2);
        check_eq("mtc0_addr", 32'(cp0_addr), 32'd12);
        check_eq("mtc0_wdata", cp0_wdata, 32'hF);
        check_eq("mtc0_stall", 32'(stall), 32'h0);
        release_bus();
        @(negedge clk);
        check_eq("mtc0_after", 32'(stall | 1'(cp0_choice != 4'b0)), 32'h0);

        drive(32'h0109_5020, 32'h0040_0304, 32'h1, 32'h2);
        @(negedge clk);
        check_eq("other_idle", 32'(stall | 1'(cp0_choice != 4'b0) | flush), 32'h0);
        release_bus();

        cp0_rdata = 32'h0080_0020;
        wb_q.push_back('{addr: 5'd9, data: 32'h0080_0020});
        drive(32'h4009_7000, 32'h0040_0308, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("mfc0_choice", 32'(cp0_choice), 32'h1);
        check_eq("mfc0_addr", 32'(cp0_addr), 32'd14);
        check_eq("mfc0_stall", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        cp0_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("mfc0_wb_we", 32'(rf_we), 32'h1);
        check_eq("mfc0_wb_stall", 32'(stall), 32'h0);
        @(negedge clk);
        check_eq("mfc0_wb_done", 32'(rf_we), 32'h0);

        cp0_rdata = 32'h0000_1234;
        wb_q.push_back('{addr: 5'd0, data: 32'h0000_1234});
        drive(32'h4000_6000, 32'h0040_030C, 32'h0, 32'h0);
        release_bus();
        @(negedge clk);
        check_eq("mfc0_r0_we", 32'(rf_we), 32'h1);

        // BREAK interrupted by reset while in REDIR: no redirect may ever appear.
        drive(32'h0000_000D, 32'h0040_0400, 32'h0, 32'h0);
        release_bus();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_mid_redirect", 32'(pc_redirect), 32'h0);
        check_eq("rst_mid_flush", 32'(flush), 32'h0);
        check_eq("rst_mid_stall", 32'(stall), 32'h0);
        check_eq("rst_mid_choice", 32'(cp0_choice), 32'h0);
        check_eq("rst_mid_cause", 32'(cp0_cause), 32'h0);
        check_eq("rst_mid_cp0_pc", cp0_pc, 32'h0);
        check_eq("rst_mid_redirect_pc", redirect_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", 32'(stall | pc_redirect | flush), 32'h0);
        end

        trap_seq("syscall2", 32'h0000_000C, 32'h0040_0500, 32'h0, 32'h0,
                 4'b1000, 4'b0000, 32'h0000_0004);
        trap_seq("eret2", 32'h4200_0018, 32'h0040_0504, 32'h0, 32'h0,
                 4'b0000, 4'b0100, 32'h0040_0024);
        trap_seq("syscall3", 32'h0000_000C, 32'h0040_0508, 32'h0, 32'h0,
                 4'b1000, 4'b0000, 32'h0000_0004);
        trap_seq("eret3", 32'h4200_0018, 32'h0040_050C, 32'h0, 32'h0,
                 4'b0000, 4'b0100, 32'h0040_0024);
        trap_seq("syscall4", 32'h0000_000C, 32'h0040_0510, 32'h0, 32'h0,
                 4'b1000, 4'b0000, 32'h0000_0004);
`ifdef TRAP_SEQ_STATS_EN
        check_eq("trap_count", trap_count, 32'd3);
        check_eq("eret_count", eret_count, 32'd2);
`endif

        repeat (2) @(negedge clk);
        check_eq("redir_q_drained", 32'(redir_q.size()), 32'h0);
        check_eq("wb_q_drained", 32'(wb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Execute-stage controller sitting directly upstream of the CP0 register block.
- Decodes SYSCALL, BREAK, TEQ, ERET, MTC0 and MFC0 from the issued instruction.
- Drives the CP0 control bundle (choice, cause, addr, wdata, pc).
- Sequences the multi-cycle trap/return: CP0 update, PC redirect, pipeline flush, and MFC0 register-file writeback.

Parameters:
- FLUSH_CYCLES, 2: bubble cycles held after a redirect (1..7).
- PC_W, 32: PC and data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instr/pc/rs_data/rt_data are valid this cycle.
- instr  in  32  MIPS instruction word.
- pc  in  32  PC of instr.
- rs_data  in  32  GPR[rs] value.
- rt_data  in  32  GPR[rt] value.
- cp0_exc_addr  in  32  CP0 exception/return target (combinational from CP0).
- cp0_rdata  in  32  CP0 read data.
- cp0_choice  out  4  {teq, eret, mtc0, mfc0} to CP0.
- cp0_cause  out  4  exception code to CP0.
- cp0_addr  out  5  CP0 register index (instr[15:11]).
- cp0_wdata  out  32  rt_data for MTC0.
- cp0_pc  out  32  PC of the trapping instruction.
- stall  out  1  upstream must hold instr.
- flush  out  1  kill younger pipeline contents.
- pc_redirect  out  1  one-cycle load of redirect_pc into the PC.
- redirect_pc  out  32  target address.
- rf_we  out  1  GPR write for MFC0.
- rf_waddr  out  5  GPR index (instr[20:16]).
- rf_wdata  out  32  CP0 value written to the GPR.

Behaviour:
- Decode (valid only with instr_valid in IDLE):
  - SYSCALL: op=0, funct=0x0C.
  - BREAK: op=0, funct=0x0D.
  - TEQ: op=0, funct=0x34.
  - ERET: op=0x10, rs=0x10, funct=0x18.
  - MTC0: op=0x10, rs=0x04.
  - MFC0: op=0x10, rs=0x00.
  - Anything else: no action, all outputs idle.
- Cause codes: SYSCALL=4'b1000, BREAK=4'b1001, TEQ=4'b1101, otherwise 4'b0000.
- States: IDLE, TRAP, REDIR, FLUSH, MFC_WB.
- IDLE:
  - MTC0: cp0_choice=0010 combinationally for the issue cycle; no stall; remain IDLE.
  - MFC0: cp0_choice=0001 and stall=1 this cycle; capture cp0_rdata, rt index at the edge; go to MFC_WB.
  - TEQ with rs_data!=rt_data: no-op, single cycle.
  - SYSCALL/BREAK/taken TEQ/ERET: stall=1; register cause, pc, and eret/teq flags; go to TRAP.
- TRAP (1 cycle):
  - Drive cp0_cause, cp0_pc, and cp0_choice (teq bit only for taken TEQ, eret bit only for ERET).
  - stall=1.
  - Capture cp0_exc_addr into redirect_pc at the edge. It must be sampled while eret is still asserted, because CP0 returns 0x4 once eret drops.
  - Go to REDIR.
- REDIR (1 cycle): pc_redirect=1, flush=1, stall=1; load counter with FLUSH_CYCLES; go to FLUSH.
- FLUSH: flush=1, stall=1; decrement counter; go to IDLE when the counter reaches 1.
- MFC_WB (1 cycle): rf_we=1 with the captured index/data, stall=0; go to IDLE.
- Total trap latency, issue to IDLE: 3+FLUSH_CYCLES cycles. pc_redirect is asserted exactly once per trap.
- instr_valid in any non-IDLE state is ignored; upstream holds the instruction under stall.
- The block always redirects on SYSCALL/BREAK/taken TEQ. CP0 status masking only affects whether CP0 records state.
- Reset (rst=0, any time, including mid-trap):
  - Immediately return to IDLE.
  - All outputs 0, cp0_choice=0000, counter 0.
  - No pc_redirect is emitted after reset deasserts.
- An rf_waddr=0 write is issued unchanged; the register file discards it.

Optional Feature:
- Macro TRAP_SEQ_STATS_EN.
- When defined: adds output trap_count[31:0] and eret_count[31:0].
  - Each increments on the TRAP→REDIR transition for exceptions and ERETs respectively.
  - Both wrap at 2^32 and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package trap_pkg:
  - Opcode/rs/funct constants.
  - Cause codes.
  - Choice bit indices (TEQ=3, ERET=2, MTC0=1, MFC0=0).
  - State enum.
- Sub-module trap_decode: purely combinational classifier producing is_syscall/is_break/is_teq/is_eret/is_mtc0/is_mfc0 plus the cause code.

Test Plan:
- SYSCALL (0x0000000C) at pc=0x00400020 → TRAP: cause=1000, choice=0000, cp0_pc=0x00400020. cp0_exc_addr=0x4 → pc_redirect one cycle later with redirect_pc=0x4. flush held 1+FLUSH_CYCLES cycles, then IDLE.
- TEQ with rs=rt=0x5 → choice=1000, cause=1101, redirect taken. Same TEQ with rt=0x6 → no stall, no redirect, choice=0000.
- ERET (0x42000018) with CP0 returning 0x00400024 during TRAP → redirect_pc=0x00400024 even though CP0 drops to 0x4 afterwards.
- MTC0 $t0→CP0[12], rt_data=0xF → choice=0010, addr=12, wdata=0xF, stall never asserted. MFC0 $t1←CP0[14] with rdata=0x00800020 → next cycle rf_we=1, rf_waddr=9, rf_wdata=0x00800020.
- BREAK, then rst low during REDIR → all outputs 0 immediately. After release, no pc_redirect appears and the next SYSCALL is processed normally.
- With TRAP_SEQ_STATS_EN defined: 3 SYSCALLs and 2 ERETs → trap_count=3, eret_count=2.
